load_store_array: RTL
=====================

// Module: load_store_array
// PURPOSE
//  Parametrised multi-channel fill/drain level oscillator. Each channel is a
//  saturating up/down level counter with its own mode bit. Channels fill to HI,
//  then drain to LO, then repeat. Flags full/empty per channel, plus an aggregate
//  full-event count. Sits beside the single-channel load/store benches as the
//  scalable instance for safety+liveness model checking.
// PARAMETERS
//  CHANNELS  4     number of independent channels (>=1)
//  CBITS     13    level counter width
//  HI        5000  upper level; full threshold
//  LO        0     lower level; empty threshold
//  STEP      1     level change per enabled cycle
//  EVBITS    16    width of full-event counter
//  Elaboration $error unless: LO < HI < 2**CBITS; 1 <= STEP <= HI-LO.
// PORTS
//  clk          in   1              rising-edge clock
//  rst_n        in   1              synchronous reset, active low
//  en           in   CHANNELS       per-channel step enable
//  force_drain  in   CHANNELS       per-channel drain command
//  full         out  CHANNELS       level == HI (registered)
//  empty        out  CHANNELS       level == LO (registered)
//  filling      out  CHANNELS       mode bit: 1=FILL, 0=DRAIN
//  any_full     out  1              |full (combinational from regs)
//  full_events  out  EVBITS         saturating count of full rising edges
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge, any state): level=LO, mode=DRAIN, full=0,
//    empty=1, full_events=0. Reset overrides all other inputs.
//  - Per channel, per cycle, in priority order:
//    1. force_drain=1: mode<=DRAIN; level unchanged. Applies even if en=0.
//    2. en=0: hold level and mode.
//    3. FILL: if level>=HI then mode<=DRAIN, level held;
//       else level<=min(level+STEP,HI). Add in CBITS+1 bits, no wrap.
//    4. DRAIN: if level<=LO then mode<=FILL, level held;
//       else level<=(level<LO+STEP) ? LO : level-STEP. No underflow.
//  - full/empty are computed from the NEXT level value and registered with it.
//    Latency 0: full rises in the same cycle the level reaches HI.
//  - Full dwell is 2 cycles: the reach cycle, then the turn-around cycle.
//    Empty dwell is the same.
//  - full_events += popcount(full_next & ~full) each cycle.
//    Saturates at 2**EVBITS-1.
//  - Channels are fully independent; simultaneous events are not arbitrated.
//  - Invariants (asserted): LO <= level <= HI; never full & empty together.
//    FILL & !full -> level strictly rises next enabled cycle.
//  - Liveness (asserted): under always rst_n & en[i] & !force_drain[i],
//    filling[i] -> (filling[i] s_until full[i]).
// STRUCTURE
//  - load_store_pkg: mode_t enum {DRAIN=1'b0, FILL=1'b1}; and a popcount
//    function.
//  - Sub-module load_store_channel: one channel (level, mode, full, empty).
//    Parameters CBITS/HI/LO/STEP; instantiated CHANNELS times by generate.
//  - Top: generate loop, any_full reduction, full_events counter, assertions.
// TESTING  (bench params CHANNELS=2 CBITS=4 HI=10 LO=2 STEP=3)
//  - Reset, en=11 held: level 2,2,5,8,10,10,7,4,2,2,5.
//    filling 0,1,1,1,1,0,0,0,0,1,1. full at cycles 4-5. empty at 0-1 and 8-9.
//  - Saturation: 8+3 clamps to 10, never 11; 4-3 clamps to 2, never 1.
//    Level stays within [2,10] over 100 cycles of random en.
//  - en[1]=0 throughout: channel 1 holds level 2, DRAIN, empty=1.
//    Channel 0 unaffected.
//  - force_drain[0]=1 at level 5 in FILL: next cycle filling[0]=0, level 5.
//    Drain then resumes 2, and FILL restarts.
//  - Both channels reach HI in the same cycle: full_events +2, any_full=1.
//    Preset full_events near max: it saturates at 65535 (EVBITS=16 build).
//  - rst_n=0 mid-fill at level 8: next cycle level=2, DRAIN, full=0, empty=1,
//    full_events=0.

Source files
------------

// File: rtl/load_store_array_pkg.sv
// Shared types and helpers for the fill/drain level oscillator array.
package load_store_array_pkg;

    typedef enum logic {DRAIN = 1'b0, FILL = 1'b1} mode_t;

    // Widest channel vector the popcount helper accepts; callers zero-extend.
    localparam int PC_W = 256;

    function automatic logic [8:0] popcount(input logic [PC_W-1:0] v);
        logic [8:0] n;
        n = '0;
        for (int i = 0; i < PC_W; i++) n = n + 9'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/load_store_array_if.sv
// Per-channel control and status bundle of the level oscillator array.
interface load_store_array_if #(
    parameter int CHANNELS = 4,
    parameter int EVBITS   = 16
);
    logic [CHANNELS-1:0] en;
    logic [CHANNELS-1:0] force_drain;
    logic [CHANNELS-1:0] full;
    logic [CHANNELS-1:0] empty;
    logic [CHANNELS-1:0] filling;
    logic                any_full;
    logic [EVBITS-1:0]   full_events;

    modport master (
        output en, force_drain,
        input  full, empty, filling, any_full, full_events
    );

    modport slave (
        input  en, force_drain,
        output full, empty, filling, any_full, full_events
    );
endinterface

// File: rtl/load_store_array_channel.sv
// One saturating fill/drain level counter with its mode bit and level flags.
module load_store_array_channel
    import load_store_array_pkg::*;
#(
    parameter int CBITS = 13,
    parameter int HI    = 5000,
    parameter int LO    = 0,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             force_drain,
    output logic [CBITS-1:0] level,
    output mode_t            mode,
    output logic             full,
    output logic             empty,
    output logic             full_next
);
    localparam logic [CBITS-1:0] HI_C   = CBITS'(HI);
    localparam logic [CBITS-1:0] LO_C   = CBITS'(LO);
    localparam logic [CBITS-1:0] STEP_C = CBITS'(STEP);
    localparam logic [CBITS:0]   HI_W   = (CBITS+1)'(HI);
    localparam logic [CBITS:0]   LO_W   = (CBITS+1)'(LO);
    localparam logic [CBITS:0]   STEP_W = (CBITS+1)'(STEP);

    logic [CBITS-1:0] level_nxt;
    mode_t            mode_nxt;
    logic [CBITS:0]   sum;
    logic             empty_next;

    // One extra bit on the add so the clamp sees overshoot instead of a wrap.
    assign sum = {1'b0, level} + STEP_W;

    always_comb begin
        level_nxt = level;
        mode_nxt  = mode;
        if (force_drain) begin
            mode_nxt = DRAIN;
        end else if (en) begin
            if (mode == FILL) begin
                if ({1'b0, level} >= HI_W) mode_nxt = DRAIN;
                else level_nxt = (sum >= HI_W) ? HI_C : sum[CBITS-1:0];
            end else begin
                if ({1'b0, level} <= LO_W) mode_nxt = FILL;
                else level_nxt = ({1'b0, level} < LO_W + STEP_W) ? LO_C : level - STEP_C;
            end
        end
    end

    assign full_next  = (level_nxt == HI_C);
    assign empty_next = (level_nxt == LO_C);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level <= LO_C;
            mode  <= DRAIN;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            level <= level_nxt;
            mode  <= mode_nxt;
            full  <= full_next;
            empty <= empty_next;
        end
    end

endmodule

// File: rtl/load_store_array.sv
// Array of independent fill/drain channels with aggregate full flag and
// a saturating count of full rising edges.
module load_store_array
    import load_store_array_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int CBITS    = 13,
    parameter int HI       = 5000,
    parameter int LO       = 0,
    parameter int STEP     = 1,
    parameter int EVBITS   = 16
) (
    input logic              clk,
    input logic              rst_n,
    load_store_array_if.slave bus
);
    if (!(LO < HI && HI < (1 << CBITS))) begin : g_bad_range
        $error("load_store_array: need LO < HI < 2**CBITS");
    end
    if (!(STEP >= 1 && STEP <= HI - LO)) begin : g_bad_step
        $error("load_store_array: need 1 <= STEP <= HI-LO");
    end
    if (CHANNELS < 1 || CHANNELS > PC_W) begin : g_bad_ch
        $error("load_store_array: CHANNELS out of range");
    end

    localparam logic [CBITS-1:0] HI_C     = CBITS'(HI);
    localparam logic [CBITS-1:0] LO_C     = CBITS'(LO);
    localparam logic [CBITS:0]   FILL_MAX = (CBITS+1)'((HI - LO + STEP - 1) / STEP);
    localparam int               SW       = EVBITS + 10;
    localparam logic [SW-1:0]    EV_MAX   = (SW'(1) << EVBITS) - SW'(1);

    logic [CHANNELS-1:0][CBITS-1:0] level;
    mode_t                          mode_v [CHANNELS];
    logic [CHANNELS-1:0]            full_v, empty_v, full_nxt, filling_v;
    logic [EVBITS-1:0]              events_q;
    logic [SW-1:0]                  ev_sum;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        load_store_array_channel #(
            .CBITS(CBITS), .HI(HI), .LO(LO), .STEP(STEP)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .en         (bus.en[i]),
            .force_drain(bus.force_drain[i]),
            .level      (level[i]),
            .mode       (mode_v[i]),
            .full       (full_v[i]),
            .empty      (empty_v[i]),
            .full_next  (full_nxt[i])
        );
        assign filling_v[i] = (mode_v[i] == FILL);

        // Checkers: range, flag exclusion, strict rise, bounded time to full.
        logic             seen_q, arm_q;
        logic [CBITS-1:0] lvl_q;
        logic [CBITS:0]   fill_cnt;
        logic             fill_arm;

        assign fill_arm = bus.en[i] && !bus.force_drain[i] && filling_v[i] && !full_v[i];

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                seen_q   <= 1'b1;
                arm_q    <= 1'b0;
                fill_cnt <= '0;
            end else begin
                if (seen_q) begin
                    assert (level[i] >= LO_C && level[i] <= HI_C);
                    assert (!(full_v[i] && empty_v[i]));
                    assert (!arm_q || level[i] > lvl_q);
                    assert (fill_cnt <= FILL_MAX);
                end
                arm_q <= fill_arm;
                if (!filling_v[i] || full_v[i]) fill_cnt <= '0;
                else if (fill_arm)              fill_cnt <= fill_cnt + 1'b1;
            end
            lvl_q <= level[i];
        end
    end

    // Several channels may hit HI together, so the step can exceed one.
    assign ev_sum = SW'(events_q) + SW'(popcount(PC_W'(full_nxt & ~full_v)));

    always_ff @(posedge clk) begin
        if (!rst_n)             events_q <= '0;
        else if (ev_sum > EV_MAX) events_q <= EV_MAX[EVBITS-1:0];
        else                    events_q <= ev_sum[EVBITS-1:0];
    end

    assign bus.full        = full_v;
    assign bus.empty       = empty_v;
    assign bus.filling     = filling_v;
    assign bus.any_full    = |full_v;
    assign bus.full_events = events_q;

endmodule
